// File: rtl/lsu_nbload_cam.sv
// Non-blocking load CAM: tracks outstanding loads by destination register,
// raises per-port source-register hazards, and issues a registered writeback
// request when the load data returns.
// Optional feature macro: RV_NBLOAD_CAM_BYPASS_EN (suppress the hazard of an
// entry whose data is returning in the same cycle).
module lsu_nbload_cam #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int NUM_LK = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  output logic                 alloc_ready,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic                 kill_valid,
  input  logic [4:0]           kill_rd,
  input  logic                 ret_valid,
  input  logic [TAG_W-1:0]     ret_tag,
  input  logic [NUM_LK*5-1:0]  lk_rs,
  output logic [NUM_LK-1:0]    lk_stall,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [TAG_W-1:0]     wb_tag,
  output logic [TAG_W:0]       pend_cnt,
  output logic                 proto_err
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wb_q, wb_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  logic             wb_valid_d;
  logic [4:0]       wb_rd_d;
  logic [TAG_W-1:0] wb_tag_d;
  logic [TAG_W:0]   pend_cnt_d;
  logic             proto_err_d;

  logic             alloc_fire;
  logic [DEPTH-1:0] ret_hit_vec;
  logic             ret_hit;

  // Lowest free entry wins the next allocation.
  always_comb begin
    alloc_ready = 1'b0;
    alloc_tag   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_ready = 1'b1;
        alloc_tag   = TAG_W'(i);
      end
    end
  end

  assign alloc_fire = alloc_valid & alloc_ready;

  // Decode the returning tag; tags beyond DEPTH never hit.
  always_comb begin
    ret_hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ret_hit_vec[i] = ret_valid && (ret_tag == TAG_W'(i)) && valid_q[i];
    end
  end

  assign ret_hit = |ret_hit_vec;

  // Entry update: supersede/kill clears first, then retirement reads the
  // cleared wb, then the allocation writes its (necessarily free) entry.
  always_comb begin
    valid_d    = valid_q;
    wb_d       = wb_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_tag_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] &&
          ((alloc_fire && (rd_q[i] == alloc_rd)) ||
           (kill_valid && (kill_rd != 5'd0) && (rd_q[i] == kill_rd)))) begin
        wb_d[i] = 1'b0;
      end
      if (ret_hit_vec[i]) begin
        wb_valid_d = wb_d[i];
        wb_rd_d    = rd_q[i];
        wb_tag_d   = TAG_W'(i);
        valid_d[i] = 1'b0;
        wb_d[i]    = 1'b0;
      end
      if (alloc_fire && (alloc_tag == TAG_W'(i))) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = alloc_rd;
        wb_d[i]    = (alloc_rd != 5'd0);
      end
    end
  end

  // Occupancy of the next-state valid vector, so pend_cnt tracks valid_q.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + (TAG_W + 1)'(valid_d[i]);
    end
  end

  assign proto_err_d = (ret_valid & ~ret_hit) | (alloc_valid & ~alloc_ready);

  // Per-port hazard against pending entries that will still write back.
  always_comb begin
    lk_stall = '0;
    for (int p = 0; p < NUM_LK; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RV_NBLOAD_CAM_BYPASS_EN
        if (valid_q[i] && wb_q[i] && !ret_hit_vec[i] && (rd_q[i] == lk_rs[p*5 +: 5]) &&
            (lk_rs[p*5 +: 5] != 5'd0)) begin
          lk_stall[p] = 1'b1;
        end
`else
        if (valid_q[i] && wb_q[i] && (rd_q[i] == lk_rs[p*5 +: 5]) &&
            (lk_rs[p*5 +: 5] != 5'd0)) begin
          lk_stall[p] = 1'b1;
        end
`endif
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q   <= '0;
      wb_q      <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_tag    <= '0;
      pend_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      wb_valid  <= wb_valid_d;
      wb_rd     <= wb_rd_d;
      wb_tag    <= wb_tag_d;
      pend_cnt  <= pend_cnt_d;
      proto_err <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_nbload_cam.sv
// Scenario bench for lsu_nbload_cam (DEPTH=4, NUM_LK=4). Expected writebacks
// are queued when a return is driven and compared one cycle later.
module tb_lsu_nbload_cam;

  logic        clk;
  logic        rst_l;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        ret_valid;
  logic [1:0]  ret_tag;
  logic [19:0] lk_rs;
  logic [3:0]  lk_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_tag;
  logic [2:0]  pend_cnt;
  logic        proto_err;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic [1:0] tag;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t ex;
  int vectors;
  int miscompares;

  lsu_nbload_cam #(.DEPTH(4), .TAG_W(2), .NUM_LK(4)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .kill_valid  (kill_valid),
    .kill_rd     (kill_rd),
    .ret_valid   (ret_valid),
    .ret_tag     (ret_tag),
    .lk_rs       (lk_rs),
    .lk_stall    (lk_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_tag      (wb_tag),
    .pend_cnt    (pend_cnt),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    kill_valid  = 1'b0;
    kill_rd     = '0;
    ret_valid   = 1'b0;
    ret_tag     = '0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle();
    lk_rs = {5'd0, 5'd0, 5'd0, 5'd0};
    #2;
    vectors++;
    if (alloc_ready !== 1'b1 || alloc_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_alloc: got ready=%b tag=%0d want ready=1 tag=0", alloc_ready, alloc_tag);
    end
    vectors++;
    if (pend_cnt !== 3'd0 || wb_valid !== 1'b0 || proto_err !== 1'b0 || lk_stall !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_outs: got pend=%0d wbv=%b perr=%b stall=%b want 0 0 0 0000",
               pend_cnt, wb_valid, proto_err, lk_stall);
    end
    tick();
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd5;
    #1;
    vectors++;
    if (alloc_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL basic_tag: got %0d want 0", alloc_tag);
    end
    tick();
    idle();
    lk_rs = {5'd0, 5'd5, 5'd0, 5'd5};
    #1;
    vectors++;
    if (pend_cnt !== 3'd1) begin
      miscompares++;
      $display("FAIL basic_pend: got %0d want 1", pend_cnt);
    end
    vectors++;
    if (lk_stall !== 4'b0101) begin
      miscompares++;
      $display("FAIL basic_stall: got %b want 0101", lk_stall);
    end
    lk_rs     = '0;
    ret_valid = 1'b1;
    ret_tag   = 2'd0;
    sb.push_back('{v: 1'b1, rd: 5'd5, tag: 2'd0});
    tick();
    idle();
    ex = sb.pop_front();
    vectors++;
    if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_tag !== ex.tag) begin
      miscompares++;
      $display("FAIL basic_wb: got v=%b rd=%0d tag=%0d want v=%b rd=%0d tag=%0d",
               wb_valid, wb_rd, wb_tag, ex.v, ex.rd, ex.tag);
    end
    vectors++;
    if (pend_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_pend_after: got %0d want 0", pend_cnt);
    end
    tick();
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wb_pulse: got %b want 0", wb_valid);
    end
  endtask

  task automatic test_full();
    logic [4:0] drain_rd [4];
    drain_rd[0] = 5'd1;
    drain_rd[1] = 5'd2;
    drain_rd[2] = 5'd10;
    drain_rd[3] = 5'd4;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      #1;
      vectors++;
      if (alloc_tag !== 2'(i) || alloc_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL full_tag%0d: got tag=%0d ready=%b want tag=%0d ready=1",
                 i, alloc_tag, alloc_ready, i);
      end
      tick();
    end
    idle();
    #1;
    vectors++;
    if (alloc_ready !== 1'b0 || pend_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL full_state: got ready=%b pend=%0d want ready=0 pend=4", alloc_ready, pend_cnt);
    end
    alloc_valid = 1'b1;
    alloc_rd    = 5'd6;
    tick();
    idle();
    vectors++;
    if (proto_err !== 1'b1 || pend_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL full_overflow: got perr=%b pend=%0d want perr=1 pend=4", proto_err, pend_cnt);
    end
    // Return and a dropped allocation in the same cycle: freed slot not usable yet.
    ret_valid   = 1'b1;
    ret_tag     = 2'd2;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd6;
    sb.push_back('{v: 1'b1, rd: 5'd3, tag: 2'd2});
    tick();
    idle();
    ex = sb.pop_front();
    vectors++;
    if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_tag !== ex.tag) begin
      miscompares++;
      $display("FAIL full_ret2: got v=%b rd=%0d tag=%0d want v=%b rd=%0d tag=%0d",
               wb_valid, wb_rd, wb_tag, ex.v, ex.rd, ex.tag);
    end
    vectors++;
    if (proto_err !== 1'b1 || pend_cnt !== 3'd3 || alloc_ready !== 1'b1 || alloc_tag !== 2'd2) begin
      miscompares++;
      $display("FAIL full_refill: got perr=%b pend=%0d ready=%b tag=%0d want 1 3 1 2",
               proto_err, pend_cnt, alloc_ready, alloc_tag);
    end
    alloc_valid = 1'b1;
    alloc_rd    = 5'd10;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1'b1;
      ret_tag   = 2'(i);
      sb.push_back('{v: 1'b1, rd: drain_rd[i], tag: 2'(i)});
      tick();
      idle();
      ex = sb.pop_front();
      vectors++;
      if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_tag !== ex.tag) begin
        miscompares++;
        $display("FAIL full_drain%0d: got v=%b rd=%0d tag=%0d want v=%b rd=%0d tag=%0d",
                 i, wb_valid, wb_rd, wb_tag, ex.v, ex.rd, ex.tag);
      end
    end
    vectors++;
    if (pend_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL full_empty: got pend=%0d want 0", pend_cnt);
    end
  endtask

  task automatic test_kill();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd7;
    tick();
    idle();
    lk_rs = {5'd0, 5'd0, 5'd8, 5'd7};
    #1;
    vectors++;
    if (lk_stall !== 4'b0001) begin
      miscompares++;
      $display("FAIL kill_pre: got stall=%b want 0001", lk_stall);
    end
    kill_valid = 1'b1;
    kill_rd    = 5'd7;
    tick();
    idle();
    vectors++;
    if (lk_stall !== 4'b0000) begin
      miscompares++;
      $display("FAIL kill_post: got stall=%b want 0000", lk_stall);
    end
    // Kill and allocation of the same register together: the new entry survives.
    alloc_valid = 1'b1;
    alloc_rd    = 5'd8;
    kill_valid  = 1'b1;
    kill_rd     = 5'd8;
    tick();
    idle();
    vectors++;
    if (lk_stall !== 4'b0010) begin
      miscompares++;
      $display("FAIL kill_alloc_same: got stall=%b want 0010", lk_stall);
    end
    // kill_rd of zero must not disturb anything.
    kill_valid = 1'b1;
    kill_rd    = 5'd0;
    tick();
    idle();
    lk_rs = '0;
    ret_valid = 1'b1;
    ret_tag   = 2'd0;
    sb.push_back('{v: 1'b0, rd: 5'd7, tag: 2'd0});
    tick();
    idle();
    ex = sb.pop_front();
    vectors++;
    if (wb_valid !== ex.v) begin
      miscompares++;
      $display("FAIL kill_ret0: got v=%b want v=%b", wb_valid, ex.v);
    end
    ret_valid = 1'b1;
    ret_tag   = 2'd1;
    sb.push_back('{v: 1'b1, rd: 5'd8, tag: 2'd1});
    tick();
    idle();
    ex = sb.pop_front();
    vectors++;
    if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_tag !== ex.tag || pend_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL kill_ret1: got v=%b rd=%0d tag=%0d pend=%0d want v=%b rd=%0d tag=%0d pend=0",
               wb_valid, wb_rd, wb_tag, pend_cnt, ex.v, ex.rd, ex.tag);
    end
  endtask

  task automatic test_supersede();
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      ret_valid = 1'b1;
      ret_tag   = 2'(i);
      sb.push_back('{v: (i == 1), rd: 5'd9, tag: 2'(i)});
      tick();
      idle();
      ex = sb.pop_front();
      vectors++;
      if (wb_valid !== ex.v || (ex.v && (wb_rd !== ex.rd || wb_tag !== ex.tag))) begin
        miscompares++;
        $display("FAIL supersede_ret%0d: got v=%b rd=%0d tag=%0d want v=%b rd=%0d tag=%0d",
                 i, wb_valid, wb_rd, wb_tag, ex.v, ex.rd, ex.tag);
      end
    end
  endtask

  task automatic test_bypass();
    logic exp_stall;
`ifdef RV_NBLOAD_CAM_BYPASS_EN
    exp_stall = 1'b0;
`else
    exp_stall = 1'b1;
`endif
    alloc_valid = 1'b1;
    alloc_rd    = 5'd3;
    tick();
    idle();
    lk_rs     = {5'd0, 5'd0, 5'd0, 5'd3};
    ret_valid = 1'b1;
    ret_tag   = 2'd0;
    sb.push_back('{v: 1'b1, rd: 5'd3, tag: 2'd0});
    #1;
    vectors++;
    if (lk_stall[0] !== exp_stall) begin
      miscompares++;
      $display("FAIL bypass_stall: got %b want %b", lk_stall[0], exp_stall);
    end
    tick();
    idle();
    lk_rs = '0;
    ex = sb.pop_front();
    vectors++;
    if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_tag !== ex.tag) begin
      miscompares++;
      $display("FAIL bypass_wb: got v=%b rd=%0d tag=%0d want v=%b rd=%0d tag=%0d",
               wb_valid, wb_rd, wb_tag, ex.v, ex.rd, ex.tag);
    end
    ret_valid = 1'b1;
    ret_tag   = 2'd1;
    tick();
    idle();
    vectors++;
    if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_bad_ret: got perr=%b wbv=%b want perr=1 wbv=0", proto_err, wb_valid);
    end
    tick();
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_perr_pulse: got %b want 0", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(11 + i);
      tick();
    end
    idle();
    // Retire tag 0 so a writeback is in flight when reset hits.
    ret_valid = 1'b1;
    ret_tag   = 2'd0;
    tick();
    idle();
    vectors++;
    if (wb_valid !== 1'b1 || pend_cnt !== 3'd2) begin
      miscompares++;
      $display("FAIL rstmid_pre: got wbv=%b pend=%0d want wbv=1 pend=2", wb_valid, pend_cnt);
    end
    lk_rs = {5'd0, 5'd0, 5'd13, 5'd12};
    rst_l = 1'b0;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || pend_cnt !== 3'd0 || lk_stall !== 4'd0 || proto_err !== 1'b0 ||
        alloc_ready !== 1'b1 || alloc_tag !== 2'd0 || wb_rd !== 5'd0 || wb_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got wbv=%b pend=%0d stall=%b perr=%b ready=%b tag=%0d rd=%0d wtag=%0d want 0 0 0000 0 1 0 0 0",
               wb_valid, pend_cnt, lk_stall, proto_err, alloc_ready, alloc_tag, wb_rd, wb_tag);
    end
    tick();
    rst_l = 1'b1;
    lk_rs = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (wb_valid !== 1'b0 || pend_cnt !== 3'd0) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: got wbv=%b pend=%0d want 0 0", i, wb_valid, pend_cnt);
      end
    end
    ret_valid = 1'b1;
    ret_tag   = 2'd1;
    tick();
    idle();
    vectors++;
    if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_stale_ret: got perr=%b wbv=%b want perr=1 wbv=0", proto_err, wb_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_full();
    test_kill();
    test_supersede();
    test_bypass();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_nbload_cam.md
LSU_NBLOAD_CAM -- requirements
Module: lsu_nbload_cam

Interface
REQ-001 Parameter DEPTH, 4, number of outstanding non-blocking load entries (2..16).
REQ-002 Parameter TAG_W, $clog2(DEPTH), entry tag width.
REQ-003 Parameter NUM_LK, 4, number of source-register lookup ports.
REQ-004 clk  input  1  core clock.
REQ-005 rst_l  input  1  reset; one clock, reset asynchronous, active-low.
REQ-006 alloc_valid  input  1  allocate entry for a new non-blocking load.
REQ-007 alloc_rd  input  5  destination register of the allocating load.
REQ-008 alloc_ready  output  1  at least one free entry.
REQ-009 alloc_tag  output  TAG_W  index of the lowest free entry.
REQ-010 kill_valid  input  1  a non-load instruction commits a write to kill_rd.
REQ-011 kill_rd  input  5  register written by that instruction.
REQ-012 ret_valid  input  1  load data returns.
REQ-013 ret_tag  input  TAG_W  tag of the returning load.
REQ-014 lk_rs  input  NUM_LK*5  packed lookup source registers.
REQ-015 lk_stall  output  NUM_LK  per-port hazard: rs matches a pending entry with wb set.
REQ-016 wb_valid  output  1  registered regfile write request.
REQ-017 wb_rd  output  5  registered regfile destination.
REQ-018 wb_tag  output  TAG_W  registered tag of the retired entry.
REQ-019 pend_cnt  output  TAG_W+1  number of valid entries.
REQ-020 proto_err  output  1  registered pulse: ret_valid to an invalid entry, or alloc_valid while alloc_ready low.

Function
REQ-021 Each entry SHALL hold valid, wb, rd[4:0], matching the existing load_cam_pkt_t fields.
REQ-022 alloc_ready and alloc_tag SHALL be combinational from the current valid vector; lowest free index wins.
REQ-023 alloc_valid with alloc_ready SHALL set entry alloc_tag next cycle: valid=1, rd=alloc_rd, wb=(alloc_rd!=0).
REQ-024 alloc_valid SHALL also clear wb in every other valid entry whose rd equals alloc_rd (younger load supersedes).
REQ-025 kill_valid SHALL clear wb in every valid entry whose rd equals kill_rd; kill_rd=0 SHALL have no effect.
REQ-026 Alloc and kill in the same cycle SHALL both apply; a kill matching alloc_rd SHALL NOT clear the newly allocated entry.
REQ-027 ret_valid to a valid entry SHALL clear its valid next cycle; wb_valid SHALL equal that entry's wb (after same-cycle kill/alloc clears), wb_rd/wb_tag its rd/tag, all one cycle after ret_valid.
REQ-028 ret_valid to an invalid entry SHALL change no state and SHALL pulse proto_err next cycle; alloc_valid with alloc_ready low SHALL be dropped and pulse proto_err.
REQ-029 Return and allocation in the same cycle SHALL not interact: freed index becomes allocatable the following cycle.
REQ-030 lk_stall[i] SHALL be combinational: OR over entries of valid & wb & (rd==lk_rs[i]) & (lk_rs[i]!=0).
REQ-031 pend_cnt SHALL be the registered population count of valid; range 0..DEPTH.
REQ-032 Latency: allocation visible to lookups one cycle after alloc_valid; writeback request one cycle after ret_valid.

Reset
REQ-033 rst_l low SHALL asynchronously clear all valid, wb, rd, wb_valid, wb_rd, wb_tag, pend_cnt and proto_err to 0; alloc_ready=1, alloc_tag=0 follow.
REQ-034 Reset mid-operation SHALL discard all outstanding entries; no wb_valid after deassertion without new allocation and return.

Configuration
REQ-035 Macro RV_NBLOAD_CAM_BYPASS_EN: when defined, lk_stall[i] SHALL be suppressed for an entry receiving ret_valid in the same cycle (return forwards data); when undefined, that entry still stalls that cycle.

Verification
REQ-036 Reset, alloc rd=5 -> alloc_tag=0, next cycle pend_cnt=1, lk_rs=5 gives lk_stall=1; ret tag 0 -> next cycle wb_valid=1 wb_rd=5 wb_tag=0, pend_cnt=0.
REQ-037 DEPTH=4: four allocs -> tags 0,1,2,3, alloc_ready=0; fifth alloc -> proto_err pulse, pend_cnt stays 4; ret tag 2 -> next alloc gets tag 2.
REQ-038 Alloc rd=7 tag 0, then kill_rd=7 -> lk_stall for rs 7 drops to 0; ret tag 0 -> wb_valid=0, entry freed.
REQ-039 Alloc rd=9 tag 0, then alloc rd=9 tag 1 -> ret tag 0 gives wb_valid=0; ret tag 1 gives wb_valid=1 wb_rd=9.
REQ-040 Alloc rd=3 then ret tag 0 with lk_rs=3 same cycle -> lk_stall=0 with RV_NBLOAD_CAM_BYPASS_EN, 1 without; ret to free tag 1 -> proto_err=1, no wb_valid.
REQ-041 rst_l asserted with 3 entries pending -> all outputs 0 immediately, alloc_ready=1, no spurious wb_valid after release.
